dmem_resp: RTL and testbench

Data-memory responder: the memory-side end of the core's MEM-stage data port. It accepts the core's address, valid, read/write, mask-mode and sign-extension signals, and returns read data combinationally. Stores are byte-masked and commit on the clock edge. Misaligned, out-of-range and illegal-mode accesses are suppressed, reported through a sticky error flag, and the responder keeps read and write access counters for debug.

---
 rtl/dmem_resp_if.sv | 47 ++++
 rtl/dmem_resp.sv | 193 +++++++++++++++++++
 tb/tb_dmem_resp.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Purpose : MEM-stage data-port bundle between the core (master) and the data-memory responder (slave).
// Latency : pure wiring; dmem_readData is returned combinationally within the request cycle.
// Backpr. : none; there is no handshake back to the core, so every request is taken in its own cycle.
//
// Signals:
//   dmem_addr       byte address of the access
//   dmem_valid      access request this cycle
//   dmem_writeData  store data, LSB-aligned (byte in [7:0], half in [15:0])
//   dmem_memRead    read request
//   dmem_memWrite   write request
//   dmem_maskMode   0=byte, 1=half, 2=word, 3=illegal
//   dmem_sext       1=sign-extend, 0=zero-extend sub-word reads
//   dmem_readData   read result back to the core
interface dmem_resp_if;
  logic [31:0] dmem_addr;
  logic        dmem_valid;
  logic [31:0] dmem_writeData;
  logic        dmem_memRead;
  logic        dmem_memWrite;
  logic [1:0]  dmem_maskMode;
  logic        dmem_sext;
  logic [31:0] dmem_readData;

  // Core side: issues requests, consumes read data.
  modport master (
    output dmem_addr,
    output dmem_valid,
    output dmem_writeData,
    output dmem_memRead,
    output dmem_memWrite,
    output dmem_maskMode,
    output dmem_sext,
    input  dmem_readData
  );

  // Memory side: consumes requests, produces read data.
  modport slave (
    input  dmem_addr,
    input  dmem_valid,
    input  dmem_writeData,
    input  dmem_memRead,
    input  dmem_memWrite,
    input  dmem_maskMode,
    input  dmem_sext,
    output dmem_readData
  );
endinterface

// File: rtl/dmem_resp.sv
// Purpose : data-memory responder for the core's MEM stage: byte-masked word array with access checking,
//           a sticky access-error flag with first-error address, and read/write debug counters.
// Latency : reads 0 cycles (combinational); writes commit on the rising edge, visible the next cycle.
// Backpr. : none; every request is served in its own cycle, back-to-back, with no stall.
//
// Ports:
//   clk       core clock, all state updates on the rising edge
//   reset_n   asynchronous active-low reset; clears flags/counters, blocks writes, forces readData to 0
//   bus       dmem_resp_if.slave request/response bundle from the core
//   err_clr   clears the sticky error flag on the edge (a same-cycle illegal access wins)
//   err       sticky access-error flag
//   err_addr  address of the first illegal access since the last clear
//   rd_count  number of accepted legal reads (wraps)
//   wr_count  number of accepted legal writes (wraps)
module dmem_resp #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter string       MEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_resp_if.slave  bus,
  input  logic        err_clr,
  output logic        err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Storage. Deliberately not reset: contents survive reset.
  logic [31:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic [31:0]   offset;
  logic          in_range;
  logic          aligned;
  logic          req;
  logic          legal;
  logic          illegal;
  logic [AW-1:0] idx;
  logic [1:0]    lane;

  // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned upper-bits
  // test covers both ends of the window.
  assign offset   = bus.dmem_addr - BASE_ADDR;
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign idx      = offset[AW+1:2];
  assign lane     = bus.dmem_addr[1:0];

  // Mode 3 falls to the default arm and is never aligned, which makes it illegal.
  always_comb begin
    aligned = 1'b0;
    case (bus.dmem_maskMode)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~lane[0];
      2'd2:    aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign req     = bus.dmem_valid & (bus.dmem_memRead | bus.dmem_memWrite);
  assign legal   = req & aligned & in_range;
  assign illegal = req & ~legal;

  // ---------------------------------------------------------------------------
  // Read path: combinational from the array, so a read in the same cycle as a
  // write sees the pre-write contents.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [31:0] lane_shift;
  logic [31:0] rd_data;

  assign rd_word = mem_q[idx];

  always_comb begin
    // Bring the addressed lane down to bit 0; a half is aligned so lane[0]=0.
    lane_shift = rd_word >> {lane, 3'b000};
    rd_data    = 32'd0;
    case (bus.dmem_maskMode)
      2'd0:    rd_data = {{24{bus.dmem_sext & lane_shift[7]}},  lane_shift[7:0]};
      2'd1:    rd_data = {{16{bus.dmem_sext & lane_shift[15]}}, lane_shift[15:0]};
      2'd2:    rd_data = rd_word;
      default: rd_data = 32'd0;
    endcase
  end

  // Only a legal read drives data; idle, illegal and reset cycles return 0.
  assign bus.dmem_readData = (reset_n & legal & bus.dmem_memRead) ? rd_data : 32'd0;

  // ---------------------------------------------------------------------------
  // Write path: byte enables plus store data replicated into every lane, so the
  // enable alone decides which bytes change.
  // ---------------------------------------------------------------------------
  logic [3:0]  be;
  logic [31:0] wdat;
  logic        we;

  always_comb begin
    be   = 4'b0000;
    wdat = bus.dmem_writeData;
    case (bus.dmem_maskMode)
      2'd0: begin
        be   = 4'b0001 << lane;
        wdat = {4{bus.dmem_writeData[7:0]}};
      end
      2'd1: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.dmem_writeData[15:0]}};
      end
      2'd2: begin
        be   = 4'b1111;
        wdat = bus.dmem_writeData;
      end
      default: begin
        be   = 4'b0000;
        wdat = bus.dmem_writeData;
      end
    endcase
  end

  // reset_n gates the enable so a store caught by reset is dropped while the
  // array itself keeps its contents.
  assign we = reset_n & legal & bus.dmem_memWrite;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdat[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error flag and debug counters
  // ---------------------------------------------------------------------------
  logic        err_q,      err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;

    if (err_clr) begin
      err_d = 1'b0;
    end
    // An illegal access beats a same-cycle clear. The address is only captured
    // when this is the first error, and a same-cycle clear makes it the first.
    if (illegal) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_addr_d = bus.dmem_addr;
      end
    end

    // Natural 32-bit wrap at all-ones.
    if (legal && bus.dmem_memRead) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (legal && bus.dmem_memWrite) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'd0;
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Purpose : self-checking bench for dmem_resp against a byte-array reference model.
// Latency : read data sampled 1 ns after the inputs change; registered outputs 1 ns after the edge.
// Backpr. : none; one request per clock.
module tb_dmem_resp;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        err_clr;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  dmem_resp_if bus();

  dmem_resp #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE),
    .MEM_INIT ("")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .err_clr (err_clr),
    .err     (err),
    .err_addr(err_addr),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: memory as little-endian bytes, plus expected flags/counters.
  logic [7:0]  ref_b [NBYTES];
  logic        exp_err;
  logic [31:0] exp_err_addr;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;

  int n_cmp;
  int n_bad;

  function automatic bit is_legal(input logic [31:0] a, input bit v, input bit rd, input bit wr,
                                  input logic [1:0] m);
    longint off;
    int     sz;
    if (!v || !(rd || wr) || m == 2'd3) return 1'b0;
    sz  = 1 << m;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= longint'(NBYTES)) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] m, input bit sx);
    int unsigned o;
    int          sz;
    logic [31:0] v;
    o  = a - BASE;
    sz = 1 << m;
    v  = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_b[o + k]) << (8 * k));
    if (sx && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] wd);
    int unsigned o;
    int          sz;
    o  = a - BASE;
    sz = 1 << m;
    for (int k = 0; k < sz; k++) ref_b[o + k] = wd[8 * k +: 8];
  endfunction

  // Drives one request for the coming edge, samples the combinational read
  // data, and advances the model by the effect of that edge.
  task automatic do_op(input logic [31:0] a, input bit v, input bit rd, input bit wr,
                       input logic [1:0] m, input bit sx, input logic [31:0] wd, input bit clr,
                       output logic [31:0] obs, output logic [31:0] expv, output bit defined);
    bit lg;
    @(negedge clk);
    bus.dmem_addr      = a;
    bus.dmem_valid     = v;
    bus.dmem_memRead   = rd;
    bus.dmem_memWrite  = wr;
    bus.dmem_maskMode  = m;
    bus.dmem_sext      = sx;
    bus.dmem_writeData = wd;
    err_clr            = clr;
    #1;
    obs     = bus.dmem_readData;
    lg      = is_legal(a, v, rd, wr, m);
    expv    = (lg && rd) ? m_read(a, m, sx) : 32'd0;
    defined = !(lg && wr && !rd);
    if (lg && wr) m_write(a, m, wd);
    if (lg && rd) exp_rd = exp_rd + 32'd1;
    if (lg && wr) exp_wr = exp_wr + 32'd1;
    if (v && (rd || wr) && !lg) begin
      if (!exp_err || clr) exp_err_addr = a;
      exp_err = 1'b1;
    end else if (clr) begin
      exp_err = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.dmem_valid    = 1'b0;
    bus.dmem_memRead  = 1'b0;
    bus.dmem_memWrite = 1'b0;
    err_clr           = 1'b0;
  endtask

  task automatic test_reset();
    bus.dmem_addr      = 32'h10;
    bus.dmem_valid     = 1'b1;
    bus.dmem_memRead   = 1'b1;
    bus.dmem_memWrite  = 1'b1;
    bus.dmem_maskMode  = 2'd2;
    bus.dmem_sext      = 1'b0;
    bus.dmem_writeData = 32'h1234_5678;
    err_clr            = 1'b0;
    reset_n            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.dmem_readData !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.dmem_readData); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (err_addr !== 32'd0) begin n_bad++; $display("FAIL reset_err_addr: got %h want 0", err_addr); end
    n_cmp++; if (rd_count !== 32'd0) begin n_bad++; $display("FAIL reset_rd_count: got %h want 0", rd_count); end
    n_cmp++; if (wr_count !== 32'd0) begin n_bad++; $display("FAIL reset_wr_count: got %h want 0", wr_count); end
    bus.dmem_valid    = 1'b0;
    bus.dmem_memRead  = 1'b0;
    bus.dmem_memWrite = 1'b0;
    reset_n           = 1'b1;
  endtask

  task automatic preload();
    logic [31:0] o, e;
    bit d;
    for (int w = 0; w < int'(DEPTH); w++) do_op(BASE + 32'(w * 4), 1, 0, 1, 2'd2, 0, $urandom, 0, o, e, d);
    idle();
  endtask

  task automatic test_word();
    logic [31:0] o, e, r0, w0;
    bit d;
    r0 = exp_rd;
    w0 = exp_wr;
    do_op(32'h10, 1, 0, 1, 2'd2, 0, 32'hDEAD_BEEF, 0, o, e, d);
    do_op(32'h10, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL word_load: got %h want deadbeef", o); end
    @(posedge clk); #1;
    n_cmp++; if (wr_count !== w0 + 32'd1) begin n_bad++; $display("FAIL word_wr_count: got %h want %h", wr_count, w0 + 32'd1); end
    n_cmp++; if (rd_count !== r0 + 32'd1) begin n_bad++; $display("FAIL word_rd_count: got %h want %h", rd_count, r0 + 32'd1); end
  endtask

  task automatic test_byte();
    logic [31:0] o, e;
    bit d;
    do_op(32'h13, 1, 0, 1, 2'd0, 0, 32'h0000_00A5, 0, o, e, d);
    do_op(32'h10, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'hA5AD_BEEF) begin n_bad++; $display("FAIL byte_store_word: got %h want a5adbeef", o); end
    do_op(32'h13, 1, 1, 0, 2'd0, 1, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'hFFFF_FFA5) begin n_bad++; $display("FAIL byte_load_sext: got %h want ffffffa5", o); end
    do_op(32'h13, 1, 1, 0, 2'd0, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'h0000_00A5) begin n_bad++; $display("FAIL byte_load_zext: got %h want 000000a5", o); end
  endtask

  task automatic test_half();
    logic [31:0] o, e;
    bit d;
    do_op(32'h12, 1, 0, 1, 2'd1, 0, 32'h0000_8001, 0, o, e, d);
    do_op(32'h10, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'h8001_BEEF) begin n_bad++; $display("FAIL half_store_word: got %h want 8001beef", o); end
    do_op(32'h12, 1, 1, 0, 2'd1, 1, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'hFFFF_8001) begin n_bad++; $display("FAIL half_load_sext: got %h want ffff8001", o); end
    do_op(32'h10, 1, 1, 1, 2'd2, 0, 32'h1234_5678, 0, o, e, d);
    n_cmp++; if (o !== 32'h8001_BEEF) begin n_bad++; $display("FAIL rw_same_cycle_old: got %h want 8001beef", o); end
    do_op(32'h10, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'h1234_5678) begin n_bad++; $display("FAIL rw_next_cycle_new: got %h want 12345678", o); end
  endtask

  task automatic test_errors();
    logic [31:0] o, e, r0, w0;
    bit d;
    do_op(32'h11, 1, 1, 1, 2'd2, 0, 32'hCAFE_F00D, 0, o, e, d);
    n_cmp++; if (o !== 32'd0) begin n_bad++; $display("FAIL misaligned_rdata: got %h want 0", o); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL misaligned_err: got %b want 1", err); end
    n_cmp++; if (err_addr !== 32'h11) begin n_bad++; $display("FAIL misaligned_err_addr: got %h want 11", err_addr); end
    do_op(32'h10, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'h1234_5678) begin n_bad++; $display("FAIL misaligned_no_write: got %h want 12345678", o); end
    do_op(32'h15, 1, 1, 0, 2'd1, 0, 32'd0, 0, o, e, d);
    @(posedge clk); #1;
    n_cmp++; if (err_addr !== 32'h11) begin n_bad++; $display("FAIL sticky_err_addr: got %h want 11", err_addr); end
    r0 = exp_rd;
    w0 = exp_wr;
    do_op(BASE + NBYTES, 1, 1, 1, 2'd2, 0, 32'h5555_5555, 0, o, e, d);
    n_cmp++; if (o !== 32'd0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", o); end
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1 || err_addr !== 32'h11) begin n_bad++; $display("FAIL oor_err: got %b/%h want 1/11", err, err_addr); end
    n_cmp++; if (rd_count !== r0 || wr_count !== w0) begin n_bad++; $display("FAIL oor_counters: got %h/%h want %h/%h", rd_count, wr_count, r0, w0); end
    do_op(BASE, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL oor_no_alias_write: got %h want %h", o, e); end
    do_op(32'h18, 1, 1, 0, 2'd3, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== 32'd0) begin n_bad++; $display("FAIL mode3_rdata: got %h want 0", o); end
    do_op(32'h21, 1, 1, 0, 2'd2, 0, 32'd0, 1, o, e, d);
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL clr_vs_err_flag: got %b want 1", err); end
    n_cmp++; if (err_addr !== 32'h21) begin n_bad++; $display("FAIL clr_vs_err_addr: got %h want 21", err_addr); end
    do_op(32'h0, 0, 0, 0, 2'd2, 0, 32'd0, 1, o, e, d);
    @(posedge clk); #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_only: got %b want 0", err); end
  endtask

  task automatic test_subword_seq();
    logic [31:0] o, e, old, r0, w0;
    bit d;
    r0 = exp_rd;
    w0 = exp_wr;
    do_op(32'h20, 1, 1, 0, 2'd2, 0, 32'd0, 0, old, e, d);
    n_cmp++; if (old !== e) begin n_bad++; $display("FAIL subword_read: got %h want %h", old, e); end
    do_op(32'h21, 1, 0, 1, 2'd0, 0, 32'h0000_007E, 0, o, e, d);
    do_op(32'h20, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== ((old & 32'hFFFF_00FF) | 32'h0000_7E00)) begin n_bad++; $display("FAIL subword_lane1: got %h want %h", o, (old & 32'hFFFF_00FF) | 32'h0000_7E00); end
    // Counters reflect the read and the write, not the check read still in flight.
    n_cmp++; if (rd_count !== r0 + 32'd1 || wr_count !== w0 + 32'd1) begin n_bad++; $display("FAIL subword_counters: got %h/%h want %h/%h", rd_count, wr_count, r0 + 32'd1, w0 + 32'd1); end
  endtask

  task automatic test_random();
    logic [31:0] o, e, a;
    bit d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE + NBYTES + 32'($urandom_range(0, 15));
        9:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, NBYTES - 1));
      endcase
      do_op(a, $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
            1'($urandom), $urandom, $urandom_range(0, 15) == 0, o, e, d);
      if (d) begin
        n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", i, a, o, e); end
      end
      @(posedge clk); #1;
      n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, err, exp_err); end
      n_cmp++; if (err_addr !== exp_err_addr) begin n_bad++; $display("FAIL rand_err_addr[%0d]: got %h want %h", i, err_addr, exp_err_addr); end
      n_cmp++; if (rd_count !== exp_rd) begin n_bad++; $display("FAIL rand_rd_count[%0d]: got %h want %h", i, rd_count, exp_rd); end
      n_cmp++; if (wr_count !== exp_wr) begin n_bad++; $display("FAIL rand_wr_count[%0d]: got %h want %h", i, wr_count, exp_wr); end
    end
    idle();
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] o, e;
    bit d;
    do_op(32'h3, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    @(negedge clk);
    bus.dmem_addr      = 32'h40;
    bus.dmem_valid     = 1'b1;
    bus.dmem_memRead   = 1'b1;
    bus.dmem_memWrite  = 1'b1;
    bus.dmem_maskMode  = 2'd2;
    bus.dmem_writeData = ~m_read(32'h40, 2'd2, 0);
    err_clr            = 1'b0;
    reset_n            = 1'b0;
    #1;
    n_cmp++; if (bus.dmem_readData !== 32'd0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", bus.dmem_readData); end
    n_cmp++; if (err !== 1'b0 || err_addr !== 32'd0) begin n_bad++; $display("FAIL midrst_err: got %b/%h want 0/0", err, err_addr); end
    n_cmp++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin n_bad++; $display("FAIL midrst_counters: got %h/%h want 0/0", rd_count, wr_count); end
    @(posedge clk);
    @(negedge clk);
    bus.dmem_valid    = 1'b0;
    bus.dmem_memRead  = 1'b0;
    bus.dmem_memWrite = 1'b0;
    reset_n           = 1'b1;
    exp_err      = 1'b0;
    exp_err_addr = 32'd0;
    exp_rd       = 32'd0;
    exp_wr       = 32'd0;
    do_op(32'h40, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL midrst_write_dropped: got %h want %h", o, e); end
    @(posedge clk); #1;
    n_cmp++; if (rd_count !== 32'd1) begin n_bad++; $display("FAIL post_reset_first_edge: got %h want 1", rd_count); end
  endtask

  task automatic test_wrap();
    logic [31:0] o, e;
    bit d;
    idle();
    force dut.rd_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.rd_count_q;
    exp_rd = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (rd_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_preset: got %h want ffffffff", rd_count); end
    do_op(32'h40, 1, 1, 0, 2'd2, 0, 32'd0, 0, o, e, d);
    @(posedge clk); #1;
    n_cmp++; if (rd_count !== 32'd0 || exp_rd !== 32'd0) begin n_bad++; $display("FAIL wrap_rd_count: got %h want 0", rd_count); end
    idle();
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    exp_err      = 1'b0;
    exp_err_addr = 32'd0;
    exp_rd       = 32'd0;
    exp_wr       = 32'd0;
    test_reset();
    preload();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_subword_seq();
    test_random();
    test_reset_mid_write();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
